// File: rtl/floor_request_scheduler.sv
// SCAN-policy lift call scheduler: latches call buttons, steers the floor stepper and times the door dwell.
// Optional build macro EMERGENCY_RECALL_EN adds the fire_recall input and a RECALL state.
module floor_request_scheduler #(
   parameter int NUM_FLOORS  = 4,
   parameter int FLOOR_W     = 2,
   parameter int DWELL_TICKS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tick,
   input  logic [NUM_FLOORS-1:0] call_btn,
   input  logic [FLOOR_W-1:0]    present_floor,
`ifdef EMERGENCY_RECALL_EN
   input  logic                  fire_recall,
`endif
   output logic [FLOOR_W-1:0]    requested_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  dir_up,
   output logic                  door_open,
   output logic                  busy
);

   localparam int DW = $clog2(DWELL_TICKS + 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_MOVE_UP   = 3'd1,
      ST_MOVE_DOWN = 3'd2,
      ST_DOOR      = 3'd3
`ifdef EMERGENCY_RECALL_EN
      ,ST_RECALL   = 3'd4
`endif
   } state_t;

   state_t                  state_q, state_d;
   logic [NUM_FLOORS-1:0]   pending_q, pending_d;
   logic [FLOOR_W-1:0]      requested_q, requested_d;
   logic                    dir_up_q, dir_up_d;
   logic                    door_open_q, door_open_d;
   logic [DW-1:0]           dwell_q, dwell_d;

   int                      pf_i;
   logic [NUM_FLOORS-1:0]   here_mask, above_mask, below_mask;
   logic [NUM_FLOORS-1:0]   set_mask, clr_mask;
   logic [FLOOR_W-1:0]      near_up, near_dn;
   logic                    pend_here, call_here, any_above, any_below;
   logic                    ahead, behind;

   assign pf_i = int'(present_floor);

   // An out-of-range present_floor matches no floor, so it can never open the door.
   always_comb begin
      here_mask  = '0;
      above_mask = '0;
      below_mask = '0;
      near_up    = '0;
      near_dn    = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         here_mask[i]  = (i == pf_i);
         above_mask[i] = (i > pf_i);
         below_mask[i] = (i < pf_i);
      end
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (pending_q[i] && above_mask[i]) near_up = FLOOR_W'(i);
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending_q[i] && below_mask[i]) near_dn = FLOOR_W'(i);
      end
   end

   assign pend_here = |(pending_q & here_mask);
   assign call_here = |(call_btn & here_mask);
   assign any_above = |(pending_q & above_mask);
   assign any_below = |(pending_q & below_mask);
   assign ahead     = dir_up_q ? any_above : any_below;
   assign behind    = dir_up_q ? any_below : any_above;

   always_comb begin
      state_d  = state_q;
      dir_up_d = dir_up_q;
      dwell_d  = dwell_q;
      set_mask = call_btn;
      clr_mask = '0;

      case (state_q)
         ST_IDLE: begin
            if (pend_here) begin
               state_d = ST_DOOR;
            end else if (ahead) begin
               state_d = dir_up_q ? ST_MOVE_UP : ST_MOVE_DOWN;
            end else if (behind) begin
               dir_up_d = !dir_up_q;
               state_d  = dir_up_q ? ST_MOVE_DOWN : ST_MOVE_UP;
            end
         end
         ST_MOVE_UP: begin
            if (pend_here)       state_d = ST_DOOR;
            else if (!any_above) state_d = ST_IDLE;
         end
         ST_MOVE_DOWN: begin
            if (pend_here)       state_d = ST_DOOR;
            else if (!any_below) state_d = ST_IDLE;
         end
         ST_DOOR: begin
            // A call at the open door extends the dwell instead of re-latching.
            set_mask = call_btn & ~here_mask;
            if (call_here) begin
               dwell_d = DW'(DWELL_TICKS);
            end else if (dwell_q == '0) begin
               if (ahead) begin
                  state_d = dir_up_q ? ST_MOVE_UP : ST_MOVE_DOWN;
               end else if (behind) begin
                  dir_up_d = !dir_up_q;
                  state_d  = dir_up_q ? ST_MOVE_DOWN : ST_MOVE_UP;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (tick) begin
               dwell_d = dwell_q - DW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Entering DOOR serves the floor and starts a fresh dwell; a same-clk tick is dropped.
      if (state_d == ST_DOOR && state_q != ST_DOOR) begin
         dwell_d  = DW'(DWELL_TICKS);
         clr_mask = here_mask;
      end

      pending_d = (pending_q | set_mask) & ~clr_mask;

      case (state_d)
         ST_MOVE_UP:   requested_d = near_up;
         ST_MOVE_DOWN: requested_d = near_dn;
         default:      requested_d = present_floor;
      endcase
      door_open_d = (state_d == ST_DOOR);

`ifdef EMERGENCY_RECALL_EN
      if (fire_recall) begin
         state_d     = ST_RECALL;
         pending_d   = '0;
         dir_up_d    = 1'b0;
         dwell_d     = '0;
         requested_d = '0;
         door_open_d = (present_floor == '0);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pending_q   <= '0;
         requested_q <= '0;
         dir_up_q    <= 1'b1;
         door_open_q <= 1'b0;
         dwell_q     <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         requested_q <= requested_d;
         dir_up_q    <= dir_up_d;
         door_open_q <= door_open_d;
         dwell_q     <= dwell_d;
      end
   end

   assign requested_floor = requested_q;
   assign pending         = pending_q;
   assign dir_up          = dir_up_q;
   assign door_open       = door_open_q;
   assign busy            = (state_q != ST_IDLE);

endmodule
